// File: rtl/determinante_seq_if.sv
// Handshake/data bundle for the sequential determinant unit.
// The ovf signal exists only when DET_OVF_EN is defined.
interface determinante_seq_if #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
);
    logic                    start;
    logic                    mode;
    logic [9*ELEM_W-1:0]     matriz;
    logic                    busy;
    logic                    done;
    logic signed [ACC_W-1:0] det;
`ifdef DET_OVF_EN
    logic                    ovf;
`endif

    modport master (
        output start, mode, matriz,
        input  busy, done, det
`ifdef DET_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, mode, matriz,
        output busy, done, det
`ifdef DET_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/determinante_seq.sv
// Sequential 2x2 / 3x3 signed determinant with one shared multiplier.
// 2x2: acc = a*d, then acc -= b*c (3-cycle latency).
// 3x3: Sarrus terms as tmp = x*y then acc +/-= tmp*z (13-cycle latency).
// Optional macro DET_OVF_EN adds the ovf output and saturates det.
module determinante_seq #(
    parameter int ELEM_W = 8,
    parameter int ACC_W  = 32
) (
    input logic               clk,
    input logic               rst_n,
    determinante_seq_if.slave bus
);
    localparam int FULL_W = 3*ELEM_W + 2;
    localparam int PROD_W = 3*ELEM_W;
    localparam int TMP_W  = 2*ELEM_W;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                     state_q, state_d;
    logic [9*ELEM_W-1:0]        mat_q;
    logic                       mode_q;
    logic [3:0]                 step_q;
    logic signed [FULL_W-1:0]   acc_q, acc_d;
    logic signed [TMP_W-1:0]    tmp_q;
    logic signed [ACC_W-1:0]    det_q, det_d;
    logic signed [TMP_W-1:0]    mul_x;
    logic signed [ELEM_W-1:0]   mul_y;
    logic signed [PROD_W-1:0]   prod;
    logic                       sub, last, write_acc, write_tmp;
    logic                       accept, finish;
    logic [2:0]                 k;
    int unsigned                xi, yi, zi;

    // Element idx (0..8) of the row-major packing, element 0 at the MSBs.
    function automatic logic signed [ELEM_W-1:0] elem(input logic [9*ELEM_W-1:0] m,
                                                      input int unsigned idx);
        return m[(8-idx)*ELEM_W +: ELEM_W];
    endfunction

    // Operand selection for the shared multiplier and accumulator update.
    // In 2x2 mode a,b,c,d are the low four elements, i.e. indices 5..8.
    always_comb begin
        xi        = 0;
        yi        = 0;
        zi        = 0;
        sub       = 1'b0;
        last      = 1'b0;
        mul_x     = '0;
        mul_y     = '0;
        write_acc = 1'b0;
        write_tmp = 1'b0;
        k         = step_q[3:1];
        if (!mode_q) begin
            last      = (step_q == 4'd1);
            write_acc = 1'b1;
            if (!step_q[0]) begin
                mul_x = TMP_W'(elem(mat_q, 5));
                mul_y = elem(mat_q, 8);
            end else begin
                mul_x = TMP_W'(elem(mat_q, 6));
                mul_y = elem(mat_q, 7);
                sub   = 1'b1;
            end
        end else begin
            last = (step_q == 4'd11);
            case (k)
                3'd0:    begin xi = 0; yi = 4; zi = 8; end
                3'd1:    begin xi = 1; yi = 5; zi = 6; end
                3'd2:    begin xi = 2; yi = 3; zi = 7; end
                3'd3:    begin xi = 2; yi = 4; zi = 6; sub = 1'b1; end
                3'd4:    begin xi = 1; yi = 3; zi = 8; sub = 1'b1; end
                3'd5:    begin xi = 0; yi = 5; zi = 7; sub = 1'b1; end
                default: begin xi = 0; yi = 0; zi = 0; end
            endcase
            if (!step_q[0]) begin
                mul_x     = TMP_W'(elem(mat_q, xi));
                mul_y     = elem(mat_q, yi);
                write_tmp = 1'b1;
            end else begin
                mul_x     = tmp_q;
                mul_y     = elem(mat_q, zi);
                write_acc = 1'b1;
            end
        end
        prod  = PROD_W'(mul_x) * PROD_W'(mul_y);
        acc_d = sub ? acc_q - FULL_W'(prod) : acc_q + FULL_W'(prod);
    end

`ifdef DET_OVF_EN
    localparam int EXT_W = (ACC_W > FULL_W) ? ACC_W : FULL_W;
    logic signed [EXT_W-1:0] acc_ext;
    logic [EXT_W-ACC_W:0]    hi;
    logic                    ovf_d, ovf_q;

    // Saturate to the ACC_W range; overflow when the bits above the
    // ACC_W sign bit are not a pure sign extension.
    always_comb begin
        acc_ext = EXT_W'(acc_d);
        hi      = acc_ext[EXT_W-1:ACC_W-1];
        ovf_d   = !((&hi) || !(|hi));
        if (ovf_d)
            det_d = acc_ext[EXT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        else
            det_d = acc_ext[ACC_W-1:0];
    end
    assign bus.ovf = ovf_q;
`else
    // Two's-complement wrap (or sign extension) to ACC_W.
    always_comb begin
        det_d = ACC_W'(acc_d);
    end
`endif

    // Next-state logic: start is taken in IDLE and DONE, ignored in CALC.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end
            end
            CALC: begin
                if (last) begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = CALC;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand latch, step counter, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mat_q   <= '0;
            mode_q  <= 1'b0;
            step_q  <= '0;
            acc_q   <= '0;
            tmp_q   <= '0;
            det_q   <= '0;
`ifdef DET_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                mat_q  <= bus.matriz;
                mode_q <= bus.mode;
                step_q <= '0;
                acc_q  <= '0;
            end else if (state_q == CALC) begin
                step_q <= step_q + 4'd1;
                if (write_acc)
                    acc_q <= acc_d;
                if (write_tmp)
                    tmp_q <= prod[TMP_W-1:0];
            end
            if (finish) begin
                det_q <= det_d;
`ifdef DET_OVF_EN
                ovf_q <= ovf_d;
`endif
            end
        end
    end

    assign bus.busy = (state_q == CALC);
    assign bus.done = (state_q == DONE);
    assign bus.det  = det_q;
endmodule

// File: tb/tb_determinante_seq.sv
// Bench for determinante_seq: two instances (ACC_W=32 and ACC_W=16) share
// one stimulus stream; a cofactor-expansion model predicts every cycle.
module tb_determinante_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [71:0] matriz;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    determinante_seq_if #(.ELEM_W(8), .ACC_W(32)) if32 ();
    determinante_seq_if #(.ELEM_W(8), .ACC_W(16)) if16 ();

    assign if32.start  = start;
    assign if32.mode   = mode;
    assign if32.matriz = matriz;
    assign if16.start  = start;
    assign if16.mode   = mode;
    assign if16.matriz = matriz;

    determinante_seq #(.ELEM_W(8), .ACC_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    determinante_seq #(.ELEM_W(8), .ACC_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact determinant by cofactor expansion; 2x2 uses the low four elements.
    function automatic longint detf(input bit md, input logic [71:0] m);
        longint e[9];
        for (int i = 0; i < 9; i++)
            e[i] = longint'($signed(m[(8-i)*8 +: 8]));
        if (md)
            return e[0]*(e[4]*e[8] - e[5]*e[7])
                 - e[1]*(e[3]*e[8] - e[5]*e[6])
                 + e[2]*(e[3]*e[7] - e[4]*e[6]);
        return e[5]*e[8] - e[6]*e[7];
    endfunction

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64-w)) >>> (64-w);
    endfunction

    function automatic bit outside(input longint v, input int w);
        longint lim;
        lim = longint'(1) <<< (w-1);
        return (v >= lim) || (v < -lim);
    endfunction

    function automatic longint result(input longint v, input int w);
`ifdef DET_OVF_EN
        longint lim;
        lim = longint'(1) <<< (w-1);
        if (v >= lim) return lim - 1;
        if (v < -lim) return -lim;
        return v;
`else
        return wrapw(v, w);
`endif
    endfunction

    // Reference model: fixed latency, start accepted only when not busy.
    bit     m_busy = 1'b0, m_done = 1'b0, m_ovf32 = 1'b0, m_ovf16 = 1'b0;
    int     m_cnt = 0;
    longint m_full = 0, m_det32 = 0, m_det16 = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
            m_det32 = 0; m_det16 = 0; m_ovf32 = 1'b0; m_ovf16 = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy  = 1'b0;
                    m_done  = 1'b1;
                    m_det32 = result(m_full, 32);
                    m_det16 = result(m_full, 16);
                    m_ovf32 = outside(m_full, 32);
                    m_ovf16 = outside(m_full, 16);
                end
            end else if (start) begin
                m_full = detf(mode, matriz);
                m_cnt  = mode ? 12 : 2;
                m_busy = 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy32", if32.busy, m_busy);
            chk("done32", if32.done, m_done);
            chk("det32",  if32.det,  m_det32);
            chk("busy16", if16.busy, m_busy);
            chk("done16", if16.done, m_done);
            chk("det16",  if16.det,  m_det16);
`ifdef DET_OVF_EN
            chk("ovf32",  if32.ovf,  m_ovf32);
            chk("ovf16",  if16.ovf,  m_ovf16);
`endif
        end
    end

    function automatic logic [71:0] rnd_mat();
        logic [71:0] m;
        m = {8'($urandom), 32'($urandom), 32'($urandom)};
        for (int i = 0; i < 9; i++)
            if ($urandom_range(3) == 0)
                m[i*8 +: 8] = ($urandom_range(1) == 1) ? 8'h80 : 8'h7F;
        return m;
    endfunction

    // Issue one op now (sampled at the next edge), then wait for done.
    // Ends at the negedge inside the DONE cycle.
    task automatic run_op(input string nm, input bit md, input logic [71:0] m,
                          input longint e32, input longint e16, input int e_ovf16, input int lat);
        int n;
        bit seen;
        start = 1'b1; mode = md; matriz = m;
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); matriz = rnd_mat();
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (if32.done === 1'b1) seen = 1'b1;
        end
        chk({nm, "_latency"}, seen ? n : -1, lat);
        chk({nm, "_done16"}, if16.done, 1);
        chk({nm, "_busy"},   if32.busy, 0);
        chk({nm, "_det32"},  if32.det, e32);
        chk({nm, "_det16"},  if16.det, e16);
`ifdef DET_OVF_EN
        chk({nm, "_ovf16"},  if16.ovf, e_ovf16);
`else
        if (e_ovf16 < 0) $display("note: negative ovf argument ignored");
`endif
    endtask

    localparam logic [71:0] M2A   = {40'hDEADBEEF12, 32'h03050207};
    localparam logic [71:0] M2B   = {40'h123456789A, 32'h807F7F80};
    localparam logic [71:0] M3A   = 72'h02FD01020_0FF010405;
    localparam logic [71:0] M3I   = 72'h010000000100000001;
    localparam logic [71:0] M3D   = 72'h800000008000000080;
`ifdef DET_OVF_EN
    localparam longint DIAG16 = -32768;
`else
    localparam longint DIAG16 = 0;
`endif

    initial begin
        logic [71:0] tmpm;
        int n;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; matriz = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", if32.busy, 0);
        chk("reset_done", if32.done, 0);
        chk("reset_det",  if32.det,  0);
        rst_n = 1'b1;

        tmpm = M3A;
        chk("model_pin_3x3", detf(1'b1, tmpm), 49);
        tmpm = M3D;
        chk("model_pin_diag", detf(1'b1, tmpm), -2097152);

        @(negedge clk);
        run_op("2x2_basic", 1'b0, M2A, 11, 11, 0, 3);
        @(negedge clk);
        run_op("2x2_ext", 1'b0, M2B, 255, 255, 0, 3);
        run_op("2x2_b2b", 1'b0, M2B, 255, 255, 0, 3);
        @(negedge clk);
        run_op("3x3_a", 1'b1, M3A, 49, 49, 0, 13);
        @(negedge clk);
        run_op("3x3_id", 1'b1, M3I, 1, 1, 0, 13);

        // Start during CALC must be ignored.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; matriz = M3A;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 13) begin
            @(negedge clk);
            n++;
            if (n == 5) begin start = 1'b1; mode = 1'b0; matriz = '0; end
            if (n == 6) start = 1'b0;
        end
        chk("ign_done", if32.done, 1);
        chk("ign_det",  if32.det,  49);
        repeat (10) begin
            @(negedge clk);
            chk("ign_no_extra_done", if32.done, 0);
        end

        // Reset in the middle of a 3x3 op.
        start = 1'b1; mode = 1'b1; matriz = M3I;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (n < 6) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy",  if32.busy, 0);
        chk("rst_det32", if32.det,  0);
        chk("rst_det16", if16.det,  0);
        repeat (20) begin
            @(negedge clk);
            chk("rst_no_done", if32.done, 0);
        end
        run_op("post_rst", 1'b0, M2A, 11, 11, 0, 3);

        // Range limit on the 16-bit instance.
        @(negedge clk);
        run_op("diag", 1'b1, M3D, -2097152, DIAG16, 1, 13);
        run_op("after_diag", 1'b0, M2A, 11, 11, 0, 3);

        // Random traffic, including starts while busy and in DONE.
        repeat (600) begin
            @(posedge clk); #1;
            start  = ($urandom_range(2) == 0);
            mode   = 1'($urandom);
            matriz = rnd_mat();
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
